// File: rtl/gpr_wport_arb_if.sv
// rtl/gpr_wport_arb_if.sv - GPR write-port arbiter bus: WB request, secondary handshake, GPR write bus
interface gpr_wport_arb_if #(
   parameter int MAX_GPR = 32,
   parameter int RSZ     = 32
);
   logic               cpu_halt;
   logic               wb_wr;
   logic [4:0]         wb_addr;
   logic [RSZ-1:0]     wb_data;
   logic               wb_stall;
   logic               sec_valid;
   logic               sec_rdy;
   logic [4:0]         sec_addr;
   logic [RSZ-1:0]     sec_data;
   logic               Rd_wr;
   logic [4:0]         Rd_addr;
   logic [RSZ-1:0]     Rd_data;
   logic [MAX_GPR-1:0] pend_mask;

   modport master (
      output cpu_halt, wb_wr, wb_addr, wb_data, sec_valid, sec_addr, sec_data,
      input  wb_stall, sec_rdy, Rd_wr, Rd_addr, Rd_data, pend_mask
   );

   modport slave (
      input  cpu_halt, wb_wr, wb_addr, wb_data, sec_valid, sec_addr, sec_data,
      output wb_stall, sec_rdy, Rd_wr, Rd_addr, Rd_data, pend_mask
   );
endinterface

// File: rtl/gpr_wport_arb.sv
// rtl/gpr_wport_arb.sv - GPR write-port arbiter between WB and a 2-entry secondary FIFO
module gpr_wport_arb #(
   parameter int MAX_GPR    = 32,
   parameter int RSZ        = 32,
   parameter int STARVE_LIM = 4
) (
   input logic               clk_in,
   input logic               reset_in,
   gpr_wport_arb_if.slave    bus
);
   localparam int SW = $clog2(STARVE_LIM + 1);

   logic [1:0]         r_vld;
   logic               r_rd_ptr;
   logic               r_wr_ptr;
   logic [4:0]         r_addr [2];
   logic [RSZ-1:0]     r_data [2];
   logic [SW-1:0]      r_starve;
   logic [MAX_GPR-1:0] r_pend;
   logic               r_rd_wr;
   logic [4:0]         r_rd_addr;
   logic [RSZ-1:0]     r_rd_data;

   logic               w_wbq;
   logic               w_sec_ok;
   logic               w_fifo_ne;
   logic               w_sec_rdy;
   logic               w_push;
   logic               w_force;
   logic               w_sec_gnt;
   logic               w_wb_gnt;
   logic [4:0]         w_head_addr;
   logic [RSZ-1:0]     w_head_data;
   logic [1:0]         w_vld_nxt;
   logic [4:0]         w_addr_nxt [2];
   logic [MAX_GPR-1:0] w_pend_nxt;

   assign w_wbq     = bus.wb_wr & ~bus.cpu_halt & (bus.wb_addr != 5'd0)
                    & ({1'b0, bus.wb_addr} < 6'(MAX_GPR));
   assign w_sec_ok  = (bus.sec_addr != 5'd0) & ({1'b0, bus.sec_addr} < 6'(MAX_GPR));
   assign w_fifo_ne = |r_vld;
   assign w_sec_rdy = ~reset_in & ~(&r_vld);
   assign w_push    = bus.sec_valid & w_sec_rdy & w_sec_ok;

   assign w_head_addr = r_addr[r_rd_ptr];
   assign w_head_data = r_data[r_rd_ptr];
   assign w_force     = (r_starve == SW'(STARVE_LIM));

   // Matching head address goes first so the older write to that register lands before WB's
   assign w_sec_gnt = ~reset_in & w_fifo_ne
                    & (~w_wbq | w_force | (bus.wb_addr == w_head_addr));
   assign w_wb_gnt  = ~reset_in & w_wbq & ~w_sec_gnt;

   // FIFO occupancy after this cycle's push/pop, used for the registered pending mask
   always_comb begin
      w_vld_nxt     = r_vld;
      w_addr_nxt[0] = r_addr[0];
      w_addr_nxt[1] = r_addr[1];
      w_pend_nxt    = '0;
      if (w_sec_gnt) w_vld_nxt[r_rd_ptr] = 1'b0;
      if (w_push) begin
         w_vld_nxt[r_wr_ptr]  = 1'b1;
         w_addr_nxt[r_wr_ptr] = bus.sec_addr;
      end
      for (int s = 0; s < 2; s++) begin
         for (int g = 0; g < MAX_GPR; g++) begin
            if (w_vld_nxt[s] && (w_addr_nxt[s] == 5'(g))) w_pend_nxt[g] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         r_vld     <= '0;
         r_rd_ptr  <= 1'b0;
         r_wr_ptr  <= 1'b0;
         r_starve  <= '0;
         r_pend    <= '0;
         r_rd_wr   <= 1'b0;
         r_rd_addr <= '0;
         r_rd_data <= '0;
      end else begin
         r_vld  <= w_vld_nxt;
         r_pend <= w_pend_nxt;
         if (w_push) begin
            r_addr[r_wr_ptr] <= bus.sec_addr;
            r_data[r_wr_ptr] <= bus.sec_data;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_sec_gnt) r_rd_ptr <= ~r_rd_ptr;

         if (w_sec_gnt || !w_fifo_ne) r_starve <= '0;
         else if (w_wb_gnt && !w_force) r_starve <= r_starve + 1'b1;

         r_rd_wr <= w_wb_gnt | w_sec_gnt;
         if (w_wb_gnt) begin
            r_rd_addr <= bus.wb_addr;
            r_rd_data <= bus.wb_data;
         end else if (w_sec_gnt) begin
            r_rd_addr <= w_head_addr;
            r_rd_data <= w_head_data;
         end
      end
   end

   assign bus.wb_stall  = w_wbq & w_sec_gnt;
   assign bus.sec_rdy   = w_sec_rdy;
   assign bus.Rd_wr     = r_rd_wr;
   assign bus.Rd_addr   = r_rd_addr;
   assign bus.Rd_data   = r_rd_data;
   assign bus.pend_mask = r_pend;
endmodule

// File: tb/tb_gpr_wport_arb.sv
// tb/tb_gpr_wport_arb.sv - directed bench for gpr_wport_arb
module tb_gpr_wport_arb;
   logic clk;
   logic rst;
   int   n_err;
   int   n_chk;

   gpr_wport_arb_if #(.MAX_GPR(32), .RSZ(32)) bus ();

   gpr_wport_arb #(.MAX_GPR(32), .RSZ(32), .STARVE_LIM(4)) dut (
      .clk_in   (clk),
      .reset_in (rst),
      .bus      (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_err = 0;
      n_chk = 0;
      rst           = 1'b1;
      bus.cpu_halt  = 1'b0;
      bus.wb_wr     = 1'b1;
      bus.wb_addr   = 5'd5;
      bus.wb_data   = 32'h1;
      bus.sec_valid = 1'b1;
      bus.sec_addr  = 5'd6;
      bus.sec_data  = 32'h2;

      // reset held 3 cycles with requests asserted
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_rd_wr", bus.Rd_wr, 0);
         chk("rst_rd_addr", bus.Rd_addr, 0);
         chk("rst_rd_data", bus.Rd_data, 0);
         chk("rst_pend", bus.pend_mask, 0);
         chk("rst_sec_rdy", bus.sec_rdy, 0);
         chk("rst_stall", bus.wb_stall, 0);
      end
      rst = 1'b0; bus.wb_wr = 1'b0; bus.sec_valid = 1'b0;
      #1;
      chk("post_rst_sec_rdy", bus.sec_rdy, 1);
      tick();
      chk("post_rst_rd_wr", bus.Rd_wr, 0);

      // WB only
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'hDEADBEEF;
      #1 chk("wb_stall", bus.wb_stall, 0);
      tick();
      chk("wb_rd_wr", bus.Rd_wr, 1);
      chk("wb_rd_addr", bus.Rd_addr, 5);
      chk("wb_rd_data", bus.Rd_data, 32'hDEADBEEF);
      bus.wb_addr = 5'd0;
      #1 chk("wb_x0_stall", bus.wb_stall, 0);
      tick();
      chk("wb_x0_rd_wr", bus.Rd_wr, 0);
      chk("wb_x0_hold_data", bus.Rd_data, 32'hDEADBEEF);
      bus.wb_wr = 1'b0;

      // starvation: one queued x7 entry, WB continuously on x3
      bus.sec_valid = 1'b1; bus.sec_addr = 5'd7; bus.sec_data = 32'h11;
      #1 chk("starve_sec_rdy", bus.sec_rdy, 1);
      tick();
      chk("starve_pend_push", bus.pend_mask, 32'h80);
      bus.sec_valid = 1'b0;
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd3;
      for (int i = 0; i < 4; i++) begin
         bus.wb_data = 32'h30 + i;
         #1 chk("starve_wb_nostall", bus.wb_stall, 0);
         tick();
         chk("starve_wb_rd_wr", bus.Rd_wr, 1);
         chk("starve_wb_addr", bus.Rd_addr, 3);
         chk("starve_wb_data", bus.Rd_data, 32'h30 + i);
         chk("starve_pend_hold", bus.pend_mask, 32'h80);
      end
      bus.wb_data = 32'h34;
      #1 chk("starve_forced_stall", bus.wb_stall, 1);
      tick();
      chk("starve_sec_addr", bus.Rd_addr, 7);
      chk("starve_sec_data", bus.Rd_data, 32'h11);
      chk("starve_pend_clear", bus.pend_mask, 0);
      #1 chk("starve_resume_stall", bus.wb_stall, 0);
      tick();
      chk("starve_resume_addr", bus.Rd_addr, 3);
      chk("starve_resume_data", bus.Rd_data, 32'h34);
      bus.wb_wr = 1'b0;
      tick();
      chk("idle_rd_wr", bus.Rd_wr, 0);

      // same-address conflict: queued x9 commits before WB x9
      bus.sec_valid = 1'b1; bus.sec_addr = 5'd9; bus.sec_data = 32'hA;
      tick();
      bus.sec_valid = 1'b0;
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hB;
      #1 chk("same_stall", bus.wb_stall, 1);
      tick();
      chk("same_first_addr", bus.Rd_addr, 9);
      chk("same_first_data", bus.Rd_data, 32'hA);
      #1 chk("same_second_stall", bus.wb_stall, 0);
      tick();
      chk("same_second_wr", bus.Rd_wr, 1);
      chk("same_second_data", bus.Rd_data, 32'hB);
      bus.wb_wr = 1'b0;
      tick();

      // full FIFO with WB busy on x3
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
      bus.sec_valid = 1'b1; bus.sec_addr = 5'd10; bus.sec_data = 32'h1;
      tick();
      bus.sec_addr = 5'd11; bus.sec_data = 32'h2;
      #1 chk("full_rdy_one", bus.sec_rdy, 1);
      tick();
      chk("full_pend_two", bus.pend_mask, 32'h0C00);
      bus.sec_addr = 5'd0; bus.sec_data = 32'hF;
      for (int i = 0; i < 3; i++) begin
         #1 chk("full_rdy_low", bus.sec_rdy, 0);
         chk("full_wb_nostall", bus.wb_stall, 0);
         tick();
         chk("full_wb_addr", bus.Rd_addr, 3);
      end
      #1 chk("full_forced_rdy_low", bus.sec_rdy, 0);
      chk("full_forced_stall", bus.wb_stall, 1);
      tick();
      chk("full_pop_addr", bus.Rd_addr, 10);
      chk("full_pop_data", bus.Rd_data, 32'h1);
      chk("full_pend_one", bus.pend_mask, 32'h0800);
      bus.wb_wr = 1'b0;
      #1 chk("full_rdy_after_pop", bus.sec_rdy, 1);
      tick();
      chk("full_x11_addr", bus.Rd_addr, 11);
      chk("x0_push_pend", bus.pend_mask, 0);
      bus.sec_valid = 1'b0;
      tick();
      chk("x0_push_no_wr", bus.Rd_wr, 0);
      chk("x0_push_pend_idle", bus.pend_mask, 0);

      // halt: two queued entries drain, WB ignored
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd3; bus.wb_data = 32'h33;
      bus.sec_valid = 1'b1; bus.sec_addr = 5'd4; bus.sec_data = 32'h44;
      tick();
      bus.sec_addr = 5'd5; bus.sec_data = 32'h55;
      tick();
      chk("halt_pend_two", bus.pend_mask, 32'h30);
      bus.sec_valid = 1'b0; bus.cpu_halt = 1'b1;
      #1 chk("halt_stall_a", bus.wb_stall, 0);
      tick();
      chk("halt_first_addr", bus.Rd_addr, 4);
      chk("halt_first_data", bus.Rd_data, 32'h44);
      #1 chk("halt_stall_b", bus.wb_stall, 0);
      tick();
      chk("halt_second_addr", bus.Rd_addr, 5);
      chk("halt_second_data", bus.Rd_data, 32'h55);
      #1 chk("halt_stall_c", bus.wb_stall, 0);
      tick();
      chk("halt_no_wb_write", bus.Rd_wr, 0);
      chk("halt_pend_empty", bus.pend_mask, 0);
      bus.cpu_halt = 1'b0; bus.wb_wr = 1'b0;

      // reset mid-operation discards a queued entry
      bus.wb_wr = 1'b1; bus.wb_addr = 5'd3;
      bus.sec_valid = 1'b1; bus.sec_addr = 5'd6; bus.sec_data = 32'h66;
      tick();
      chk("midrst_pend_before", bus.pend_mask, 32'h40);
      bus.sec_valid = 1'b0; bus.wb_wr = 1'b0;
      rst = 1'b1;
      tick();
      chk("midrst_pend", bus.pend_mask, 0);
      chk("midrst_rd_wr", bus.Rd_wr, 0);
      rst = 1'b0;
      tick();
      chk("midrst_no_drain", bus.Rd_wr, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
